battleship_board: RTL
=====================

Name: battleship_board

Overview:
Parametrised successor to the single-sprite grid cursor. It keeps a GRID_SIZE x GRID_SIZE board of cell states (unknown/miss/hit) and moves a cursor with debounced buttons, with optional wrap-around. A fire button resolves a shot against an external ship map and counts shots and hits. It renders the board, grid lines and cursor outline as a registered pixel stream for the VGA timing block.

Parameters:
GRID_SIZE, 10, cells per side (2..15)
CELL_W, 64, cell width in pixels
CELL_H, 48, cell height in pixels
GRID_LEFT, 144, first visible hCount of grid
GRID_TOP, 35, first visible vCount of grid
LINE_THICK, 1, grid line thickness in pixels
CURSOR_THICK, 2, cursor outline thickness in pixels
COOLDOWN, 500000, debounce lockout in clk cycles after any accepted button event
WRAP, 0, 1 = cursor wraps at edges; 0 = cursor clamps at edges
SHIP_CELLS, 17, number of set bits in ship_map; sets the game-over threshold

Ports:
clk  in  1  system/pixel clock
rst_n  in  1  asynchronous active-low reset
bright  in  1  visible-area flag from VGA timing
hCount  in  10  current pixel x
vCount  in  10  current pixel y
btn_l / btn_r / btn_u / btn_d  in  1 each  direction buttons, level
btn_fire  in  1  fire button, level
new_game  in  1  synchronous clear pulse
ship_map  in  GRID_SIZE*GRID_SIZE  bit r*GRID_SIZE+c = ship present at (row r, col c); static during play
rgb  out  12  pixel colour, registered
score  out  16  hit count
shots  out  16  count of distinct cells fired on
game_over  out  1  high once score == SHIP_CELLS

Behaviour:
- Reset (rst_n low, async): rgb=0, score=0, shots=0, game_over=0, cursor (row 0, col 0), all cells UNKNOWN, button FSM IDLE, edge registers 0.
- new_game=1 at a clock edge: same effect as reset, synchronously. It overrides every other event in that cycle.
- Button FSM, states IDLE/COOL:
  - IDLE: rising edges are detected against the 1-cycle-delayed button level. Any edge acts in that same cycle, loads the counter with COOLDOWN and goes to COOL.
  - COOL: counter decrements each cycle. All edges are ignored. At counter==0 it returns to IDLE.
  - Held buttons do not repeat. A new press is required.
- Movement:
  - btn_l and btn_r edges together: left wins. btn_u and btn_d edges together: up wins.
  - A horizontal and a vertical edge in the same cycle both apply, giving a diagonal move.
  - WRAP=0: a move at the edge is a no-op, but still starts COOL.
  - WRAP=1: col 0 moving left goes to col GRID_SIZE-1, and vice versa. Rows behave the same way.
- Fire (edge accepted in IDLE, game_over=0):
  - Targets the pre-move cursor cell, even if a move edge arrives in the same cycle.
  - Cell UNKNOWN: becomes HIT if its ship_map bit is 1, else MISS. shots+1. score+1 if HIT.
  - Cell already MISS/HIT: no state or counter change.
  - Counters saturate at 16'hFFFF.
  - Fire while game_over=1 is ignored; movement is still allowed.
- game_over is registered: it rises the cycle after the hit that makes score==SHIP_CELLS and holds until reset or new_game.
- Render pipeline, latency exactly 2 clk from hCount/vCount/bright to rgb. Sync signals must be delayed 2 cycles externally.
  - Stage 1: compute in-grid flag, pixel col/row index, in-cell offsets, line flag and cursor-outline flag.
  - Stage 2: read the cell state and register rgb.
- Colour priority:
  1. !bright: 12'h000
  2. cursor outline (offset < CURSOR_THICK from any edge of the cursor cell): 12'hFF0
  3. grid line (in-cell offset < LINE_THICK): 12'hFFF
  4. HIT: 12'hF00
  5. MISS: 12'h888
  6. UNKNOWN: 12'h00F
  7. outside grid: 12'h000
- Width rules:
  - Pixel offsets are 10 bits unsigned.
  - Cell index is 8 bits (row*GRID_SIZE+col < 225).
  - Board storage is 2 bits/cell in registers; no RAM inference is required.

Decomposition:
- Package battleship_pkg: cell_state_t enum (UNKNOWN=2'b00, MISS=2'b01, HIT=2'b10), the colour constants, and a cell_index function.
- Sub-module btn_event_fsm: edge detection plus the IDLE/COOL cooldown FSM. Outputs one-cycle pulses ev_l/ev_r/ev_u/ev_d/ev_fire. Parameter COOLDOWN.

Test Plan:
- Reset then render pixel (368,155), cell row 2 col 3 interior -> rgb=12'h00F two cycles after input; pixel (144,35) -> 12'hFF0 (cursor outline at 0,0).
- COOLDOWN=4. Pulse btn_r 1 cycle, then btn_r again 2 cycles later -> col=1 only; a third press after 5+ cycles -> col=2.
- WRAP=0: at col 0, press btn_l -> col stays 0. WRAP=1: same stimulus -> col=9.
- ship_map bit 23 set, cursor at (2,3), fire -> cell HIT, score=1, shots=1, pixel (368,155) -> 12'hF00. Fire again -> counters unchanged.
- SHIP_CELLS=1 after one hit -> game_over=1. Subsequent fire on an empty cell -> shots unchanged. new_game -> all outputs return to reset values.
- Fire and btn_r edges in the same cycle at (0,0) -> cell (0,0) resolved, cursor moves to col 1.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared types, colours and helpers for the battleship board.
//   cell_state_t : per-cell shot result stored on the board
//   btn_state_t  : button cooldown FSM states
//   COLOR_*      : 12-bit RGB palette used by the renderer
//   cell_index   : flattens (row, col) into the board/ship-map index
package battleship_pkg;

    typedef enum logic [1:0] {
        UNKNOWN = 2'b00,
        MISS    = 2'b01,
        HIT     = 2'b10
    } cell_state_t;

    typedef enum logic {
        IDLE = 1'b0,
        COOL = 1'b1
    } btn_state_t;

    localparam logic [11:0] COLOR_BLACK   = 12'h000;
    localparam logic [11:0] COLOR_CURSOR  = 12'hFF0;
    localparam logic [11:0] COLOR_LINE    = 12'hFFF;
    localparam logic [11:0] COLOR_HIT     = 12'hF00;
    localparam logic [11:0] COLOR_MISS    = 12'h888;
    localparam logic [11:0] COLOR_UNKNOWN = 12'h00F;

    // row*grid_size+col always fits 8 bits for grids up to 15x15
    function automatic logic [7:0] cell_index(input logic [3:0] row,
                                              input logic [3:0] col,
                                              input int         grid_size);
        int idx;
        idx = int'(row) * grid_size + int'(col);
        return 8'(idx);
    endfunction

endpackage

// File: rtl/battleship_board_btn_event_fsm.sv
// Button edge detector with a shared cooldown lockout.
//   clk, rst_n : clock, async active-low reset
//   srst       : synchronous clear (new game)
//   btn_*      : raw button levels
//   ev_*       : one-cycle event pulses, only issued from IDLE
module btn_event_fsm
    import battleship_pkg::*;
#(
    parameter int COOLDOWN = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic srst,
    input  logic btn_l,
    input  logic btn_r,
    input  logic btn_u,
    input  logic btn_d,
    input  logic btn_fire,
    output logic ev_l,
    output logic ev_r,
    output logic ev_u,
    output logic ev_d,
    output logic ev_fire
);
    localparam int            CW       = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(COOLDOWN);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    btn_state_t    state_r;
    btn_state_t    state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic [4:0]    btn_s;
    logic [4:0]    prev_r;
    logic [4:0]    edge_s;
    logic [4:0]    ev_s;

    assign btn_s  = {btn_l, btn_r, btn_u, btn_d, btn_fire};
    // Edge register keeps tracking during COOL so a held button never re-fires
    assign edge_s = btn_s & ~prev_r;

    // Next-state and event decode: any edge in IDLE fires at once and starts the lockout
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        ev_s        = 5'b00000;
        case (state_r)
            IDLE: begin
                if (edge_s != 5'b00000) begin
                    ev_s        = edge_s;
                    cnt_nxt_s   = CNT_LOAD;
                    state_nxt_s = COOL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            COOL: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and edge-history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            prev_r  <= 5'b00000;
        end else if (srst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            prev_r  <= 5'b00000;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            prev_r  <= btn_s;
        end
    end

    assign {ev_l, ev_r, ev_u, ev_d, ev_fire} = ev_s;

endmodule

// File: rtl/battleship_board.sv
// Battleship board: cursor movement, shot resolution against a ship map,
// and a 2-stage registered renderer for a VGA timing block.
//   clk, rst_n       : clock, async active-low reset
//   bright, hCount,
//   vCount           : pixel position/visibility; rgb follows 2 clocks later
//   btn_l/r/u/d/fire : raw button levels
//   new_game         : synchronous clear, dominates everything else
//   ship_map         : bit r*GRID_SIZE+c set = ship at (r, c)
//   rgb              : registered pixel colour
//   score, shots     : saturating hit count / distinct cells fired on
//   game_over        : set the cycle after score reaches SHIP_CELLS
module battleship_board
    import battleship_pkg::*;
#(
    parameter int GRID_SIZE    = 10,
    parameter int CELL_W       = 64,
    parameter int CELL_H       = 48,
    parameter int GRID_LEFT    = 144,
    parameter int GRID_TOP     = 35,
    parameter int LINE_THICK   = 1,
    parameter int CURSOR_THICK = 2,
    parameter int COOLDOWN     = 500000,
    parameter int WRAP         = 0,
    parameter int SHIP_CELLS   = 17
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           bright,
    input  logic [9:0]                     hCount,
    input  logic [9:0]                     vCount,
    input  logic                           btn_l,
    input  logic                           btn_r,
    input  logic                           btn_u,
    input  logic                           btn_d,
    input  logic                           btn_fire,
    input  logic                           new_game,
    input  logic [GRID_SIZE*GRID_SIZE-1:0] ship_map,
    output logic [11:0]                    rgb,
    output logic [15:0]                    score,
    output logic [15:0]                    shots,
    output logic                           game_over
);
    localparam logic [3:0]  LAST    = 4'(GRID_SIZE - 1);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic        ev_l_s, ev_r_s, ev_u_s, ev_d_s, ev_fire_s;
    logic [3:0]  cur_row_r, cur_col_r, nxt_row_s, nxt_col_s;
    cell_state_t board_r [256];
    logic [15:0] score_r, shots_r;
    logic        game_over_r;
    logic [255:0] ship_ext_s;
    logic [7:0]  fire_idx_s;
    logic        fire_ok_s, fire_hit_s;

    btn_event_fsm #(.COOLDOWN(COOLDOWN)) u_btn (
        .clk(clk), .rst_n(rst_n), .srst(new_game),
        .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d), .btn_fire(btn_fire),
        .ev_l(ev_l_s), .ev_r(ev_r_s), .ev_u(ev_u_s), .ev_d(ev_d_s), .ev_fire(ev_fire_s)
    );

    // Cursor next position: left beats right, up beats down, axes independent
    always_comb begin
        nxt_col_s = cur_col_r;
        nxt_row_s = cur_row_r;
        if (ev_l_s) begin
            if (cur_col_r == 4'd0) nxt_col_s = (WRAP != 0) ? LAST : 4'd0;
            else                   nxt_col_s = cur_col_r - 4'd1;
        end else if (ev_r_s) begin
            if (cur_col_r == LAST) nxt_col_s = (WRAP != 0) ? 4'd0 : LAST;
            else                   nxt_col_s = cur_col_r + 4'd1;
        end else begin
            nxt_col_s = cur_col_r;
        end
        if (ev_u_s) begin
            if (cur_row_r == 4'd0) nxt_row_s = (WRAP != 0) ? LAST : 4'd0;
            else                   nxt_row_s = cur_row_r - 4'd1;
        end else if (ev_d_s) begin
            if (cur_row_r == LAST) nxt_row_s = (WRAP != 0) ? 4'd0 : LAST;
            else                   nxt_row_s = cur_row_r + 4'd1;
        end else begin
            nxt_row_s = cur_row_r;
        end
    end

    // Shots resolve against the cursor as it was before any same-cycle move
    assign ship_ext_s = 256'(ship_map);
    assign fire_idx_s = cell_index(cur_row_r, cur_col_r, GRID_SIZE);
    assign fire_hit_s = ship_ext_s[fire_idx_s];
    assign fire_ok_s  = ev_fire_s && !game_over_r && (board_r[fire_idx_s] == UNKNOWN);

    // Game state: cursor, board, counters and game-over latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_row_r   <= 4'd0;
            cur_col_r   <= 4'd0;
            score_r     <= 16'd0;
            shots_r     <= 16'd0;
            game_over_r <= 1'b0;
            for (int i = 0; i < 256; i++) board_r[i] <= UNKNOWN;
        end else if (new_game) begin
            cur_row_r   <= 4'd0;
            cur_col_r   <= 4'd0;
            score_r     <= 16'd0;
            shots_r     <= 16'd0;
            game_over_r <= 1'b0;
            for (int i = 0; i < 256; i++) board_r[i] <= UNKNOWN;
        end else begin
            cur_row_r <= nxt_row_s;
            cur_col_r <= nxt_col_s;
            if (fire_ok_s) begin
                board_r[fire_idx_s] <= fire_hit_s ? HIT : MISS;
                if (shots_r != CNT_MAX) shots_r <= shots_r + 16'd1;
                if (fire_hit_s && (score_r != CNT_MAX)) score_r <= score_r + 16'd1;
            end
            if (score_r == 16'(SHIP_CELLS)) game_over_r <= 1'b1;
        end
    end

    assign score     = score_r;
    assign shots     = shots_r;
    assign game_over = game_over_r;

    // ---------------- render pipeline ----------------
    logic [9:0] dx_s, dy_s, col_full_s, row_full_s, ox_s, oy_s;
    logic       in_grid_s, line_s, cur_s;
    logic [7:0] idx_s;
    logic       s1_bright_r, s1_in_r, s1_line_r, s1_cur_r;
    logic [7:0] s1_idx_r;
    logic [11:0] rgb_s, rgb_r;

    assign dx_s       = hCount - 10'(GRID_LEFT);
    assign dy_s       = vCount - 10'(GRID_TOP);
    assign col_full_s = dx_s / 10'(CELL_W);
    assign row_full_s = dy_s / 10'(CELL_H);
    assign ox_s       = dx_s % 10'(CELL_W);
    assign oy_s       = dy_s % 10'(CELL_H);
    assign in_grid_s  = (int'(hCount) >= GRID_LEFT) && (int'(hCount) < GRID_LEFT + GRID_SIZE * CELL_W)
                     && (int'(vCount) >= GRID_TOP)  && (int'(vCount) < GRID_TOP + GRID_SIZE * CELL_H);
    assign line_s     = (ox_s < 10'(LINE_THICK)) || (oy_s < 10'(LINE_THICK));
    assign cur_s      = (col_full_s == {6'd0, cur_col_r}) && (row_full_s == {6'd0, cur_row_r})
                     && ((ox_s < 10'(CURSOR_THICK)) || (ox_s >= 10'(CELL_W - CURSOR_THICK))
                      || (oy_s < 10'(CURSOR_THICK)) || (oy_s >= 10'(CELL_H - CURSOR_THICK)));
    assign idx_s      = in_grid_s ? cell_index(4'(row_full_s), 4'(col_full_s), GRID_SIZE) : 8'd0;

    // Colour select from stage-1 flags and the addressed cell state
    always_comb begin
        rgb_s = COLOR_BLACK;
        if (!s1_bright_r || !s1_in_r) begin
            rgb_s = COLOR_BLACK;
        end else if (s1_cur_r) begin
            rgb_s = COLOR_CURSOR;
        end else if (s1_line_r) begin
            rgb_s = COLOR_LINE;
        end else begin
            case (board_r[s1_idx_r])
                HIT:     rgb_s = COLOR_HIT;
                MISS:    rgb_s = COLOR_MISS;
                UNKNOWN: rgb_s = COLOR_UNKNOWN;
                default: rgb_s = COLOR_UNKNOWN;
            endcase
        end
    end

    // Stage 1 geometry registers and stage 2 colour register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_bright_r <= 1'b0;
            s1_in_r     <= 1'b0;
            s1_line_r   <= 1'b0;
            s1_cur_r    <= 1'b0;
            s1_idx_r    <= 8'd0;
            rgb_r       <= COLOR_BLACK;
        end else if (new_game) begin
            s1_bright_r <= 1'b0;
            s1_in_r     <= 1'b0;
            s1_line_r   <= 1'b0;
            s1_cur_r    <= 1'b0;
            s1_idx_r    <= 8'd0;
            rgb_r       <= COLOR_BLACK;
        end else begin
            s1_bright_r <= bright;
            s1_in_r     <= in_grid_s;
            s1_line_r   <= in_grid_s && line_s;
            s1_cur_r    <= in_grid_s && cur_s;
            s1_idx_r    <= idx_s;
            rgb_r       <= rgb_s;
        end
    end

    assign rgb = rgb_r;

endmodule
